mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle MIPS control FSM. Sequences the shared datapath (ALU, memory, register file).
//  Drives every 32-bit 2:1/4:1 mux select plus all write strobes, one instruction at a time.
//  Sits beside the datapath: consumes the IR opcode, the ALU zero flag and the memory ready flag.
// PARAMETERS
//  OPW      6  opcode field width (IR[31:26])
//  STATE_W  4  state register width
// PORTS
//  clk          in   1      rising-edge clock, single clock domain
//  reset        in   1      synchronous, active-high
//  opcode       in   OPW    IR[31:26] of the latched instruction
//  zero         in   1      ALU zero flag (beq compare)
//  mem_ready    in   1      memory completes access this cycle
//  pc_en        out  1      PC register write enable
//  iord         out  1      address mux: 0=PC, 1=ALUOut
//  mem_read     out  1      memory read strobe
//  mem_write    out  1      memory write strobe
//  ir_write     out  1      instruction register load
//  reg_dst      out  1      write-reg mux: 0=rt, 1=rd
//  mem_to_reg   out  1      write-data mux: 0=ALUOut, 1=MDR
//  reg_write    out  1      register file write enable
//  alu_src_a    out  1      0=PC, 1=A
//  alu_src_b    out  2      00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
//  alu_op       out  2      00=add, 01=sub, 10=funct-decoded
//  pc_src       out  2      00=ALU result, 01=ALUOut, 10=jump target
//  state        out  STATE_W  current state (debug)
//  illegal      out  1      high while in TRAP
// BEHAVIOUR
//  - Reset: state<=FETCH on the edge. While reset=1, pc_en/ir_write/mem_write/reg_write are forced 0.
//  - Moore decode of state. Only pc_en and ir_write are qualified by inputs.
//  - States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7
//    BRANCH=8 JUMP=9 ADDIEX=10 ADDIWB=11 TRAP=15. Any other code maps to FETCH next cycle.
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
//    ir_write=pc_en=mem_ready. Holds in FETCH until mem_ready=1, then goes to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Dispatch on opcode:
//    000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP,
//    001000->ADDIEX (macro dependent), all others->TRAP.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: lw->MEMRD, sw->MEMWR.
//  - MEMRD: iord=1, mem_read=1. Holds until mem_ready, then goes to MEMWB.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state: FETCH.
//  - MEMWR: iord=1, mem_write=1. mem_write stays high while waiting. Leaves on mem_ready to FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next state: FETCH.
//  - JUMP: pc_src=10, pc_en=1. Next state: FETCH.
//  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
//  - TRAP: all strobes 0, illegal=1. Sticky until reset.
//  - Unlisted outputs default to 0 in every state.
//  - Latency with mem_ready=1: beq/j 3 cycles, R/sw/addi 4, lw 5.
//    Each cycle with mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
//  - Reset in any state (including a wait state) aborts the instruction. FETCH is entered next cycle.
// CONFIGURATION
//  MC_ADDI_EN defined: opcode 001000 -> ADDIEX -> ADDIWB -> FETCH.
//  MC_ADDI_EN undefined: ADDIEX/ADDIWB absent; 001000 -> TRAP (illegal=1).
// TESTING
//  1. reset=1 2 cycles, mem_ready=1 -> state=0, mem_read=1, alu_src_b=01; no write strobe high during reset.
//  2. opcode=000000, mem_ready=1 -> states 0,1,6,7,0.
//     ALUWB has reg_write=1 and reg_dst=1. pc_en=1 only in the FETCH cycle.
//  3. opcode=100011, mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0.
//     iord=1 in MEMRD. MEMWB has mem_to_reg=1.
//  4. opcode=000100 with zero=1 -> pc_en=1, pc_src=01 in BRANCH. With zero=0 -> pc_en=0. Both return to 0.
//  5. opcode=111111 -> TRAP (state=15), illegal=1, held 10 cycles; reset -> state=0, illegal=0.
//  6. opcode=001000: with MC_ADDI_EN -> states 0,1,10,11,0 and reg_write=1 in state 11.
//     Without MC_ADDI_EN -> state 15.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences ALU, memory and register file one instruction at a time.
// Latency: 3 cycles for beq/j, 4 for R/sw/addi, 5 for lw, plus one cycle per mem_ready=0 cycle in FETCH/MEMRD/MEMWR.
// Backpressure: mem_ready=0 holds FETCH, MEMRD and MEMWR with their strobes asserted until memory completes.
//
// Ports:
//   clk, reset           single clock domain, synchronous active-high reset
//   opcode, zero         IR[31:26] of the latched instruction, ALU zero flag
//   mem_ready            memory completes its access this cycle
//   pc_en .. pc_src      datapath mux selects and write strobes (Moore decode of state)
//   state, illegal       debug state and TRAP indicator
// Configuration: define MC_ADDI_EN to add addi support (ADDIEX/ADDIWB). Without it, addi traps.
module mips_multicycle_ctrl #(
    parameter int OPW     = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPW-1:0]     opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(9);
`ifdef MC_ADDI_EN
    localparam logic [STATE_W-1:0] S_ADDIEX = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_ADDIWB = STATE_W'(11);
`endif
    localparam logic [STATE_W-1:0] S_TRAP   = STATE_W'(15);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:       state_d = S_ADDIEX;
`else
                    OP_ADDI:       state_d = S_TRAP;
`endif
                    default:       state_d = S_TRAP;
                endcase
            end
            // The IR is stable across the instruction, so re-checking opcode here is safe.
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`endif
            S_TRAP:   state_d = S_TRAP;
            // Unused encodings recover to FETCH.
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode: Moore on state, with pc_en/ir_write qualified by inputs
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;   // precompute branch target
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
`endif
            S_TRAP:   illegal = 1'b1;
            default: ;
        endcase
        // No architectural state may change while reset is held.
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state = state_q;

endmodule
